// File: rtl/boot_loader_if.sv
// Byte-stream and instruction-memory write bus for boot_loader.
// The slave modport is the loader side; master is the byte source / memory side.
interface boot_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream program loader: header word count, little-endian words into imem, then core release.
// Optional trailing checksum word enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
   parameter int unsigned IMEM_DEPTH = 1024,
   parameter int unsigned ADDR_W     = 10,
   parameter logic [31:0] BOOT_ADDR  = 32'hFFFF_0000
) (
   input  logic                clk,
   input  logic                rstn,
   boot_loader_if.slave        bus,
   output logic                core_rstn,
   output logic [31:0]         boot_addr,
   output logic                load_done,
   output logic                load_err
);

`ifdef BOOT_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {StHdr, StLoad, StCsum, StDone, StErr} state_e;
`else
   typedef enum logic [2:0] {StHdr, StLoad, StDone, StErr} state_e;
`endif

   // One extra bit so a count of IMEM_DEPTH words is representable.
   typedef logic [ADDR_W:0] cnt_t;

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   cnt_t              word_cnt_q, word_cnt_d;
   cnt_t              n_q, n_d;
   logic [23:0]       part_q, part_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              core_rstn_q, core_rstn_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [31:0]       sum_q, sum_d;
`endif

   logic        accept;
   logic [31:0] full_word;
   logic        last_word;

   assign accept    = bus.in_valid && ready_q;
   assign full_word = {bus.in_data, part_q};
   assign last_word = (word_cnt_q == (n_q - cnt_t'(1)));

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      n_d         = n_q;
      part_d      = part_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      core_rstn_d = (state_q == StDone);
      done_d      = (state_q == StDone);
      err_d       = (state_q == StErr);
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      if (accept) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         unique case (byte_cnt_q)
            2'd0:    part_d[7:0]   = bus.in_data;
            2'd1:    part_d[15:8]  = bus.in_data;
            2'd2:    part_d[23:16] = bus.in_data;
            default: begin
               unique case (state_q)
                  StHdr: begin
                     n_d = full_word[ADDR_W:0];
                     if (full_word == 32'd0) begin
                        state_d = StDone;
                     end else if (full_word > 32'(IMEM_DEPTH)) begin
                        state_d = StErr;
                     end else begin
                        state_d = StLoad;
                     end
                  end
                  StLoad: begin
                     we_d       = 1'b1;
                     addr_d     = word_cnt_q[ADDR_W-1:0];
                     wdata_d    = full_word;
                     word_cnt_d = word_cnt_q + cnt_t'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
                     sum_d = sum_q + full_word;
                     if (last_word) state_d = StCsum;
`else
                     if (last_word) state_d = StDone;
`endif
                  end
`ifdef BOOT_LOADER_CHECKSUM_EN
                  StCsum: begin
                     state_d = (full_word == sum_q) ? StDone : StErr;
                  end
`endif
                  default: ;
               endcase
            end
         endcase
      end

      // Registered so in_ready is low in reset and rises the first cycle after release.
      ready_d = (state_d != StDone) && (state_d != StErr);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StHdr;
         byte_cnt_q  <= 2'd0;
         word_cnt_q  <= '0;
         n_q         <= '0;
         part_q      <= '0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         core_rstn_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_cnt_q  <= word_cnt_d;
         n_q         <= n_d;
         part_q      <= part_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         core_rstn_q <= core_rstn_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.in_ready   = ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign core_rstn      = core_rstn_q;
   assign boot_addr      = BOOT_ADDR;
   assign load_done      = done_q;
   assign load_err       = err_q;

endmodule
